int_ctrl: RTL and testbench

- Platform interrupt controller that sits directly upstream of the core's CSR unit.
- Collects NUM_SRC peripheral interrupt lines, masks them, and arbitrates by fixed priority.
- Presents one request with its ID (IntReq/IntID) to the CSR unit.
- Tracks claim (IntClaim) and completion (IntRet), so only one interrupt is in service at a time.

---
 rtl/int_pkg.sv | 12 +
 rtl/int_prio_enc.sv | 23 ++
 rtl/int_ctrl.sv | 119 +++++++++++
 tb/tb_int_ctrl.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/int_pkg.sv
// rtl/int_pkg.sv - shared state encoding and default source count for int_ctrl
package int_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    SERVE = 2'd2
  } state_t;

  localparam int NUM_SRC_DEF = 2;

endpackage

// File: rtl/int_prio_enc.sv
// rtl/int_prio_enc.sv - lowest-index-wins priority encoder over the pending vector
module int_prio_enc
  import int_pkg::*;
#(
  parameter int NUM_SRC = NUM_SRC_DEF,
  parameter int ID_W    = ($clog2(NUM_SRC) > 0 ? $clog2(NUM_SRC) : 1)
) (
  input  logic [NUM_SRC-1:0] req,
  output logic [ID_W-1:0]    winner,
  output logic               any
);

  // Scan from the top down so the lowest set index is the last one written.
  always_comb begin
    winner = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (req[i]) winner = ID_W'(i);
    end
  end

  assign any = |req;

endmodule

// File: rtl/int_ctrl.sv
// rtl/int_ctrl.sv - masked fixed-priority interrupt controller with claim/complete tracking
// Define INT_EDGE_EN for edge-triggered sources; level-sensitive otherwise.
module int_ctrl
  import int_pkg::*;
#(
  parameter int                    NUM_SRC  = NUM_SRC_DEF,
  parameter int                    ID_W     = ($clog2(NUM_SRC) > 0 ? $clog2(NUM_SRC) : 1),
  parameter logic [NUM_SRC-1:0]    MASK_RST = {NUM_SRC{1'b1}}
) (
  input  logic               CK,
  input  logic               RST,
  input  logic [NUM_SRC-1:0] IRQ_SRC,
  input  logic               MASK_WEN,
  input  logic [NUM_SRC-1:0] MASK_DI,
  input  logic               IntClaim,
  input  logic               IntRet,
  output logic               IntReq,
  output logic [ID_W-1:0]    IntID,
  output logic [NUM_SRC-1:0] IntMask,
  output logic [NUM_SRC-1:0] IntPend,
  output logic               InService
);

  state_t             state;
  logic [NUM_SRC-1:0] src_q;
  logic [NUM_SRC-1:0] mask;
  logic [NUM_SRC-1:0] pending;
  logic [ID_W-1:0]    int_id;
  logic               int_req;
  logic               in_service;
  logic [ID_W-1:0]    winner;
  logic               any;

  int_prio_enc #(
    .NUM_SRC (NUM_SRC),
    .ID_W    (ID_W)
  ) u_prio (
    .req    (pending),
    .winner (winner),
    .any    (any)
  );

  always_ff @(posedge CK) begin
    if (RST) begin
      src_q <= '0;
      mask  <= MASK_RST;
    end else begin
      src_q <= IRQ_SRC;
      if (MASK_WEN) mask <= MASK_DI;
    end
  end

`ifdef INT_EDGE_EN
  logic [NUM_SRC-1:0] edge_det;
  logic [NUM_SRC-1:0] clr;

  assign edge_det = IRQ_SRC & ~src_q;
  assign clr      = (IntClaim && state == REQ) ? (NUM_SRC'(1) << int_id) : '0;

  // A new edge on the bit being claimed re-arms it; masking drops it.
  always_ff @(posedge CK) begin
    if (RST) pending <= '0;
    else     pending <= ((pending & ~clr) | edge_det) & mask;
  end
`else
  always_ff @(posedge CK) begin
    if (RST) pending <= '0;
    else     pending <= src_q & mask;
  end
`endif

  always_ff @(posedge CK) begin
    if (RST) begin
      state      <= IDLE;
      int_id     <= '0;
      int_req    <= 1'b0;
      in_service <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any) begin
            state   <= REQ;
            int_id  <= winner;
            int_req <= 1'b1;
          end
        end
        REQ: begin
          // Claim beats withdrawal; a higher-priority arrival never preempts.
          if (IntClaim) begin
            state      <= SERVE;
            int_req    <= 1'b0;
            in_service <= 1'b1;
          end else if (!pending[int_id]) begin
            state   <= IDLE;
            int_req <= 1'b0;
          end
        end
        SERVE: begin
          if (IntRet) begin
            state      <= IDLE;
            in_service <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          int_req    <= 1'b0;
          in_service <= 1'b0;
        end
      endcase
    end
  end

  assign IntReq    = int_req;
  assign IntID     = int_id;
  assign IntMask   = mask;
  assign IntPend   = pending;
  assign InService = in_service;

endmodule

// File: tb/tb_int_ctrl.sv
// tb/tb_int_ctrl.sv - directed self-checking bench for int_ctrl (level mode, or edge mode with INT_EDGE_EN)
module tb_int_ctrl;

  logic       ck = 1'b0;
  logic       rst;
  logic [1:0] irq_src;
  logic       mask_wen;
  logic [1:0] mask_di;
  logic       int_claim;
  logic       int_ret;
  logic       int_req;
  logic [0:0] int_id;
  logic [1:0] int_mask;
  logic [1:0] int_pend;
  logic       in_service;

  int n_checks = 0;
  int n_fail   = 0;

  int_ctrl dut (
    .CK        (ck),
    .RST       (rst),
    .IRQ_SRC   (irq_src),
    .MASK_WEN  (mask_wen),
    .MASK_DI   (mask_di),
    .IntClaim  (int_claim),
    .IntRet    (int_ret),
    .IntReq    (int_req),
    .IntID     (int_id),
    .IntMask   (int_mask),
    .IntPend   (int_pend),
    .InService (in_service)
  );

  always #5 ck = ~ck;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge ck);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic pulse_claim();
    int_claim = 1'b1;
    step(1);
    int_claim = 1'b0;
  endtask

  task automatic pulse_ret();
    int_ret = 1'b1;
    step(1);
    int_ret = 1'b0;
  endtask

  initial begin
    int held_low;
    rst = 1'b1; irq_src = 2'b00; mask_wen = 1'b0; mask_di = 2'b00;
    int_claim = 1'b0; int_ret = 1'b0;
    step(2);
    check("rst_req",  int_req,    0);
    check("rst_id",   int_id,     0);
    check("rst_svc",  in_service, 0);
    check("rst_mask", int_mask,   2'b11);
    check("rst_pend", int_pend,   2'b00);
    rst = 1'b0;
    step(1);

`ifdef INT_EDGE_EN
    irq_src = 2'b10;
    step(1);
    check("edge_pend_set", int_pend, 2'b10);
    irq_src = 2'b00;
    step(1);
    check("edge_req", int_req, 1);
    check("edge_id",  int_id,  1);
    step(3);
    check("edge_pend_hold", int_pend, 2'b10);
    check("edge_req_hold",  int_req,  1);
    // claim with a fresh rising edge on the same source in the same cycle
    irq_src = 2'b10;
    pulse_claim();
    irq_src = 2'b00;
    check("edge_coinc_pend", int_pend[1], 1);
    check("edge_coinc_svc",  in_service,  1);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check("edge_rst_svc",  in_service, 0);
    check("edge_rst_req",  int_req,    0);
    check("edge_rst_pend", int_pend,   2'b00);
    check("edge_rst_id",   int_id,     0);
`else
    // single source, latency three edges from the drive
    irq_src = 2'b10;
    step(2);
    check("single_req_early", int_req, 0);
    step(1);
    check("single_req", int_req, 1);
    check("single_id",  int_id,  1);
    // higher priority arrival does not preempt; IntRet in REQ is ignored
    irq_src = 2'b11;
    int_ret = 1'b1;
    step(1);
    int_ret = 1'b0;
    step(2);
    check("nopreempt_id",  int_id,  1);
    check("nopreempt_req", int_req, 1);
    pulse_claim();
    irq_src = 2'b00;
    check("claim_req", int_req,    0);
    check("claim_svc", in_service, 1);
    step(3);
    check("serve_hold_svc", in_service, 1);
    check("serve_hold_id",  int_id,     1);
    pulse_ret();
    check("ret_svc", in_service, 0);
    step(2);
    check("ret_idle_req", int_req, 0);

    // simultaneous sources: index 0 wins, and again after service
    irq_src = 2'b11;
    step(3);
    check("simul_req", int_req, 1);
    check("simul_id",  int_id,  0);
    pulse_claim();
    pulse_ret();
    step(1);
    check("simul_again_req", int_req, 1);
    check("simul_again_id",  int_id,  0);
    pulse_claim();
    irq_src = 2'b10;
    step(2);
    pulse_ret();
    step(1);
    check("drop0_req", int_req, 1);
    check("drop0_id",  int_id,  1);
    pulse_claim();
    irq_src = 2'b00;
    step(2);
    pulse_ret();
    step(2);
    check("clean_req", int_req, 0);

    // mask source 1 off, then re-enable
    mask_wen = 1'b1; mask_di = 2'b01;
    step(1);
    mask_wen = 1'b0;
    check("mask_val", int_mask, 2'b01);
    irq_src = 2'b10;
    held_low = 1;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (int_req !== 1'b0) held_low = 0;
    end
    check("masked_req_low", held_low, 1);
    check("masked_pend",    int_pend, 2'b00);
    mask_wen = 1'b1; mask_di = 2'b11;
    step(1);
    mask_wen = 1'b0;
    step(2);
    check("unmask_req", int_req, 1);
    check("unmask_id",  int_id,  1);
    irq_src = 2'b00;
    step(3);
    check("unmask_drop_req", int_req, 0);

    // withdraw without claim, then a stray claim in IDLE
    irq_src = 2'b01;
    step(3);
    check("wd_req", int_req, 1);
    irq_src = 2'b00;
    step(3);
    check("wd_gone_req", int_req, 0);
    pulse_claim();
    check("idle_claim_svc", in_service, 0);
    check("idle_claim_req", int_req,    0);

    // mask change during service is ignored, then reset mid-service
    irq_src = 2'b01;
    step(3);
    pulse_claim();
    mask_wen = 1'b1; mask_di = 2'b00;
    step(1);
    mask_wen = 1'b0;
    step(2);
    check("svc_mask_svc", in_service, 1);
    check("svc_mask_id",  int_id,     0);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    irq_src = 2'b00;
    check("midrst_svc",  in_service, 0);
    check("midrst_req",  int_req,    0);
    check("midrst_mask", int_mask,   2'b11);
    check("midrst_pend", int_pend,   2'b00);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
